// File: rtl/brick_map_ctrl.sv
// ----------------------------------------------------------------------------
// brick_map_ctrl
//
// Owns the playfield brick map and is the only block that writes it.
// A level is streamed in from ROM one row per cycle. Outside of a load, the
// bullet engines ask for individual bricks to be knocked out, and a
// round-robin arbiter services at most one of them per cycle. A running
// brick count is kept alongside the map, and level_clear fires when the last
// brick goes.
//
// Ports
//   frame_clk    clock
//   Reset        synchronous, active-high reset
//   load_start   1-cycle pulse, begin streaming a level from ROM
//   rom_addr     ROM row address (data returns one cycle later)
//   rom_data     ROM row contents, stored as-is (bit COLS-1 is screen col 0)
//   load_busy    high for the ROWS+1 cycles of a load
//   load_done    1-cycle pulse in the final load cycle
//   clr_req      per-requester clear request, held until its ack is seen
//   clr_row      packed 5-bit map row per requester
//   clr_col      packed 6-bit screen column per requester (not reversed)
//   clr_ack      one-hot, 1-cycle pulse per serviced request
//   brick_map    live map, brick_map[row][COLS-1-col]
//   bricks_left  number of set bits in brick_map
//   level_clear  1-cycle pulse with the ack that removes the last brick
// ----------------------------------------------------------------------------
module brick_map_ctrl #(
   parameter int NUM_REQ = 4,
   parameter int ROWS    = 30,
   parameter int COLS    = 40
) (
   input  logic                   frame_clk,
   input  logic                   Reset,
   input  logic                   load_start,
   output logic [4:0]             rom_addr,
   input  logic [COLS-1:0]        rom_data,
   output logic                   load_busy,
   output logic                   load_done,
   input  logic [NUM_REQ-1:0]     clr_req,
   input  logic [5*NUM_REQ-1:0]   clr_row,
   input  logic [6*NUM_REQ-1:0]   clr_col,
   output logic [NUM_REQ-1:0]     clr_ack,
   output logic [COLS-1:0]        brick_map [0:ROWS-1],
   output logic [10:0]            bricks_left,
   output logic                   level_clear
);

   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CNT_W = $clog2(ROWS + 1);

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ROWS);
   localparam logic [4:0]       ROW_LIM  = 5'(ROWS);
   localparam logic [5:0]       COL_LIM  = 6'(COLS);
   localparam logic [5:0]       COL_TOP  = 6'(COLS - 1);

   typedef enum logic [0:0] {
      ST_IDLE,
      ST_LOAD
   } state_t;

   state_t             state;
   state_t             state_next;

   logic [CNT_W-1:0]   load_cnt;
   logic [CNT_W-1:0]   load_row;
   logic [PTR_W-1:0]   rr_ptr;

   logic [4:0]         req_row [NUM_REQ];
   logic [5:0]         req_col [NUM_REQ];
   logic [NUM_REQ-1:0] eligible;
   logic               grant_valid;
   logic               grant_fire;
   logic [PTR_W-1:0]   grant_idx;
   logic [PTR_W-1:0]   next_ptr;
   logic [4:0]         sel_row;
   logic [5:0]         sel_col;
   logic               in_range;
   logic [4:0]         row_idx;
   logic [5:0]         bit_idx;
   logic               hit_brick;
   logic [NUM_REQ-1:0] ack_next;

   // State register for the load sequencer.
   always_ff @(posedge frame_clk) begin
      if (Reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state and load status outputs. A load runs for ROWS+1 cycles:
   // the extra cycle is needed because ROM data trails the address by one,
   // so the last row is written in the cycle after its address is issued.
   always_comb begin
      state_next = state;
      load_busy  = 1'b0;
      load_done  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (load_start) begin
               state_next = ST_LOAD;
            end
         end
         ST_LOAD: begin
            load_busy = 1'b1;
            if (load_cnt == LAST_CNT) begin
               load_done  = 1'b1;
               state_next = ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // The address holds at the last row during the final write cycle so the
   // ROM is never asked for a row that does not exist.
   always_comb begin
      rom_addr = (load_cnt == LAST_CNT) ? 5'(ROWS - 1) : 5'(load_cnt);
      load_row = load_cnt - 1'b1;
   end

   // Round-robin pick starting at rr_ptr. A requester whose ack is showing
   // this cycle still has its request up, so it is masked out to avoid a
   // second grant for the same request. load_start outranks every clear.
   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) begin
         req_row[i] = clr_row[i*5 +: 5];
         req_col[i] = clr_col[i*6 +: 6];
      end
      eligible    = clr_req & ~clr_ack;
      grant_valid = 1'b0;
      grant_idx   = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         logic [PTR_W-1:0] cand;
         cand = PTR_W'((int'(rr_ptr) + i) % NUM_REQ);
         if (!grant_valid && eligible[cand]) begin
            grant_valid = 1'b1;
            grant_idx   = cand;
         end
      end
      grant_fire = grant_valid && (state == ST_IDLE) && !load_start;
      next_ptr   = PTR_W'((int'(grant_idx) + 1) % NUM_REQ);
      ack_next   = '0;
      if (grant_fire) begin
         ack_next[grant_idx] = 1'b1;
      end
   end

   // Decode the winner's target cell. Screen columns are stored mirrored.
   // Out-of-range targets are still acked but must not touch the map.
   always_comb begin
      sel_row   = req_row[grant_idx];
      sel_col   = req_col[grant_idx];
      in_range  = (sel_row < ROW_LIM) && (sel_col < COL_LIM);
      row_idx   = in_range ? sel_row : 5'd0;
      bit_idx   = in_range ? (COL_TOP - sel_col) : 6'd0;
      hit_brick = grant_fire && in_range && brick_map[row_idx][bit_idx];
   end

   // Map, count, arbiter pointer and pulse outputs. A load zeroes the count
   // on entry and rebuilds it from each row written; a clear only
   // decrements when it actually removes a brick.
   always_ff @(posedge frame_clk) begin
      if (Reset) begin
         for (int r = 0; r < ROWS; r++) begin
            brick_map[r] <= '0;
         end
         bricks_left <= '0;
         load_cnt    <= '0;
         rr_ptr      <= '0;
         clr_ack     <= '0;
         level_clear <= 1'b0;
      end else begin
         clr_ack     <= ack_next;
         level_clear <= hit_brick && (bricks_left == 11'd1);
         case (state)
            ST_IDLE: begin
               if (load_start) begin
                  load_cnt    <= '0;
                  bricks_left <= '0;
               end else if (grant_fire) begin
                  rr_ptr <= next_ptr;
                  if (hit_brick) begin
                     brick_map[row_idx][bit_idx] <= 1'b0;
                     bricks_left                 <= bricks_left - 11'd1;
                  end
               end
            end
            ST_LOAD: begin
               if (load_cnt != '0) begin
                  brick_map[load_row] <= rom_data;
                  bricks_left         <= bricks_left + 11'($countones(rom_data));
               end
               if (load_cnt == LAST_CNT) begin
                  load_cnt <= '0;
               end else begin
                  load_cnt <= load_cnt + 1'b1;
               end
            end
            default: load_cnt <= '0;
         endcase
      end
   end

endmodule
